// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 selector bus with a bounded hold time.
// Outputs are fully registered; grants appear one edge after the request is sampled.
module mux41_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [3:0] iReq,
    output logic [3:0] oGnt,
    output logic       oS1,
    output logic       oS0,
    output logic       oValid,
    output logic [7:0] oHoldCnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;

    logic [1:0] win;
    logic       others;
    logic       grant_en;

    // First requesting channel scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [3:0] req);
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        grant_en = 1'b0;
        win      = pick(ptr_q, iReq);
        others   = |(iReq & ~(4'b0001 << owner_q));

        case (state_q)
            IDLE: begin
                if (|iReq) grant_en = 1'b1;
            end
            GRANT: begin
                if (!iReq[owner_q]) begin
                    if (|iReq) begin
                        grant_en = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                    end
                end else if (hold_q >= HOLD_LIM && others) begin
                    // ptr already points past the owner, so the owner is scanned last.
                    grant_en = 1'b1;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_en) begin
            state_d = GRANT;
            owner_d = win;
            ptr_d   = win + 2'd1;
            hold_d  = 8'd0;
            gnt_d   = 4'b0001 << win;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= 8'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign oGnt     = gnt_q;
    assign oS1      = owner_q[1];
    assign oS0      = owner_q[0];
    assign oValid   = valid_q;
    assign oHoldCnt = hold_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Bench for mux41_rr_arbiter: two instances (HOLD_MAX=4 and HOLD_MAX=1) share stimulus
// and are compared every cycle against a behavioural round-robin model.
module tb_mux41_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt   [2];
    logic       s1    [2];
    logic       s0    [2];
    logic       vld   [2];
    logic [7:0] hcnt  [2];

    int errors = 0;
    int checks = 0;

    int m_valid [2];
    int m_owner [2];
    int m_hold  [2];
    int m_ptr   [2];
    int hmax    [2] = '{4, 1};

    always #5 clk = ~clk;

    mux41_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .iClk(clk), .iRst_n(rst_n), .iReq(req),
        .oGnt(gnt[0]), .oS1(s1[0]), .oS0(s0[0]), .oValid(vld[0]), .oHoldCnt(hcnt[0])
    );

    mux41_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
        .iClk(clk), .iRst_n(rst_n), .iReq(req),
        .oGnt(gnt[1]), .oS1(s1[1]), .oS0(s0[1]), .oValid(vld[1]), .oHoldCnt(hcnt[1])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_grant(input int n, input int w);
        m_valid[n] = 1;
        m_owner[n] = w;
        m_hold[n]  = 0;
        m_ptr[n]   = (w + 1) % 4;
    endtask

    task automatic model_edge(input int n, input logic rn, input logic [3:0] r);
        int k;
        if (!rn) begin
            m_valid[n] = 0; m_owner[n] = 0; m_hold[n] = 0; m_ptr[n] = 0;
        end else if (m_valid[n] == 0) begin
            if (r != 0) model_grant(n, rr_pick(m_ptr[n], r));
        end else begin
            k = m_owner[n];
            if (!r[k]) begin
                if (r != 0) model_grant(n, rr_pick(m_ptr[n], r));
                else m_valid[n] = 0;
            end else if (m_hold[n] >= hmax[n] - 1 && (r & ~(4'b0001 << k)) != 0) begin
                model_grant(n, rr_pick(m_ptr[n], r));
            end else if (m_hold[n] < 255) begin
                m_hold[n] = m_hold[n] + 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("gnt%0d", n), int'(gnt[n]), m_valid[n] ? (1 << m_owner[n]) : 0);
            chk($sformatf("sel%0d", n), int'({s1[n], s0[n]}), m_owner[n]);
            chk($sformatf("valid%0d", n), int'(vld[n]), m_valid[n]);
            chk($sformatf("hold%0d", n), int'(hcnt[n]), m_hold[n]);
        end
    endtask

    // Apply inputs, take one rising edge, advance the model, then compare after the edge.
    task automatic step(input logic rn, input logic [3:0] r);
        rst_n = rn;
        req   = r;
        @(posedge clk);
        model_edge(0, rn, r);
        model_edge(1, rn, r);
        #1;
        compare_all();
    endtask

    initial begin
        logic [3:0] rq;
        int         seq [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
        #1;

        // Reset with all channels requesting
        step(1'b0, 4'b1111);
        step(1'b0, 4'b1111);
        chk("rst_gnt", int'(gnt[0]), 0);
        chk("rst_sel", int'({s1[0], s0[0]}), 0);
        chk("rst_valid", int'(vld[0]), 0);
        step(1'b1, 4'b1111);
        chk("first_gnt", int'(gnt[0]), 1);
        chk("first_hold", int'(hcnt[0]), 0);

        // Full contention: four-cycle tenures rotating through all channels
        for (int i = 1; i < 17; i++) begin
            step(1'b1, 4'b1111);
            chk("contend_sel", int'({s1[0], s0[0]}), seq[i]);
            chk("contend_hold", int'(hcnt[0]), i % 4);
        end

        // Early release from ch2 straight to ch3
        step(1'b0, 4'b0000);
        step(1'b1, 4'b0100);
        chk("ch2_gnt", int'(gnt[0]), 4);
        step(1'b1, 4'b1001);
        chk("handoff_gnt", int'(gnt[0]), 8);
        chk("handoff_valid", int'(vld[0]), 1);
        step(1'b1, 4'b0000);
        chk("idle_gnt", int'(gnt[0]), 0);
        chk("idle_sel", int'({s1[0], s0[0]}), 3);

        // Lone requester saturates the hold counter, then yields to a newcomer
        for (int i = 0; i < 300; i++) step(1'b1, 4'b0010);
        chk("lone_gnt", int'(gnt[0]), 2);
        chk("lone_sat", int'(hcnt[0]), 255);
        step(1'b1, 4'b0011);
        chk("lone_rot", int'(gnt[0]), 1);

        // HOLD_MAX=1 instance alternates ch0/ch2 every edge
        step(1'b0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b0101);
            chk("hm1_gnt", int'(gnt[1]), (i % 2 == 0) ? 1 : 4);
            chk("hm1_hold", int'(hcnt[1]), 0);
        end

        // Mid-tenure reset while ch3 holds with count 2
        step(1'b0, 4'b0000);
        step(1'b1, 4'b1000);
        step(1'b1, 4'b1000);
        step(1'b1, 4'b1000);
        chk("mid_hold", int'(hcnt[0]), 2);
        step(1'b0, 4'b1111);
        chk("mid_rst_gnt", int'(gnt[0]), 0);
        chk("mid_rst_hold", int'(hcnt[0]), 0);
        step(1'b1, 4'b1111);
        chk("post_rst_gnt", int'(gnt[0]), 1);

        // Randomized traffic with sticky requests and occasional reset
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 99) != 0), rq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
